// File: rtl/uart_tx_fifo.sv
// 8N1/8N2 UART transmitter fed by a small byte FIFO over a valid/ready port.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1/8E2).
module uart_tx_fifo #(
  parameter int unsigned CLOCK_HZ   = 6250,
  parameter int unsigned BAUD       = 781,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned CPB       = CLOCK_HZ / BAUD;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned STOP_CLKS = STOP_BITS * CPB;
  localparam int unsigned BCW       = $clog2(STOP_CLKS);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CPB - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_CLKS - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic             push, pop;
  logic             bit_end;

  assign tx_ready_o   = (count_q != FULL_CNT);
  assign push         = tx_valid_i && tx_ready_o;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;
  assign bit_end      = (baud_q == BIT_LAST);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Pops only from IDLE or at the end of STOP, so an empty FIFO never falls through.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BCW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = fifo_mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so tx_o stays a clean register output.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE) || (count_d != '0);
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

endmodule
